port_out_uart_tx: RTL and testbench
===================================

// Module: port_out_uart_tx
// PURPOSE
//  Downstream consumer of the MIPS processor output port. Each processor store to PortOut
//  (wr_en strobe) pushes one 32-bit word into a small FIFO. A serialiser drains the FIFO and
//  transmits every word as 4 UART bytes, LSB byte first (8N1, no parity). Lets programs print
//  results without stalling the pipeline. Words arriving while the FIFO is full are dropped
//  and flagged.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    4    FIFO entries (32-bit words); power of two, >= 2
// PORTS
//  clk         input   1                         system clock, rising edge
//  reset       input   1                         asynchronous, active-high; clears all state
//  wr_en       input   1                         one-cycle strobe: push wr_data
//  wr_data     input   32                        word written by the processor to PortOut
//  clear_ovf   input   1                         synchronous clear of overflow
//  tx          output  1                         UART serial line, idles high
//  busy        output  1                         serialiser not in IDLE
//  fifo_full   output  1                         FIFO holds FIFO_DEPTH words
//  fifo_empty  output  1                         FIFO holds 0 words
//  overflow    output  1                         sticky: a push was dropped
//  level       output  $clog2(FIFO_DEPTH)+1      number of words in FIFO
// BEHAVIOUR
//  Reset values: tx=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0, level=0, FSM=IDLE.
//   - Reset mid-frame aborts the frame: tx goes high immediately; FIFO contents discarded.
//  FIFO
//   - Push when wr_en && !fifo_full, judged on the registered state at the clock edge.
//   - If wr_en && fifo_full, the word is dropped and overflow sets. This holds even if a
//     pop happens in the same cycle.
//   - Push and pop in the same cycle (not full): level is unchanged; both take effect.
//   - Pointers wrap modulo FIFO_DEPTH. full/empty/level are registered, derived from level.
//  Overflow
//   - Sticky. clear_ovf clears it next cycle.
//   - Set has priority over clear when both occur in the same cycle.
//  Serialiser FSM states: IDLE, START, DATA, STOP.
//   - Counters: baud counter 0..CLKS_PER_BIT-1, bit_idx 0..7, byte_idx 0..3.
//   - IDLE: if !fifo_empty, pop the head into a 32-bit shift reg, byte_idx=0, go to START.
//     Otherwise stay; tx=1.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   - DATA: tx = current byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles.
//     After bit 7, go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<3, byte_idx++ and go to START;
//     else go to IDLE.
//   - Byte n is shift_reg[8n+7:8n].
//  tx and busy are registered outputs (glitch-free). busy = (state != IDLE).
//  Latency
//   - wr_en at edge k into an empty FIFO with the FSM idle: fifo_empty=0 after edge k.
//   - Pop at edge k+1; tx falls after edge k+1.
//   - One word takes 40*CLKS_PER_BIT cycles, followed by exactly 1 IDLE cycle before the next
//     word's start bit.
//  wr_data is sampled only on accepted pushes; later changes to PortOut do not affect the
//  word in flight.
// STRUCTURE
//  Shared include mips_io_defs.vh:
//   - FSM state localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3)
//   - UART_BYTES_PER_WORD=4
//   - default CLKS_PER_BIT
//  Sub-module sync_fifo #(WIDTH=32, DEPTH=FIFO_DEPTH):
//   - registered pointers and level; ports push/pop/din/dout/full/empty/level
//   - dout is combinational from the head entry.
//  Top level holds the overflow logic, the baud/bit/byte counters, the shift reg and the FSM.
// TESTING (run with CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset: hold reset 3 cycles -> tx=1, busy=0, fifo_empty=1, level=0, overflow=0.
//     Assert reset mid-DATA -> tx=1 the same cycle, FSM IDLE, level=0.
//  2. Single word: push 32'h4F4B0A41 -> bytes 8'h41,8'h0A,8'h4B,8'h4F decoded from tx.
//     Each byte has start bit 0 and stop bit 1. Total 160 cycles from the first falling edge.
//     busy drops 1 cycle after the last stop bit.
//  3. Back-to-back: push 5 words on consecutive cycles -> all 5 accepted (one is popped
//     while the others queue), level peaks at 4, no overflow.
//     Bytes arrive in order with 1 idle cycle between words.
//  4. Overflow: keep FSM busy, fill to 4, then push 32'hDEADBEEF -> dropped; overflow=1;
//     level stays 4. clear_ovf together with another dropped push -> overflow stays 1.
//     clear_ovf alone -> overflow=0 next cycle.
//  5. Simultaneous push/pop: FIFO has 1 word, FSM returns to IDLE on the same edge as
//     wr_en -> level stays 1, both words are transmitted in order.
//  6. Pointer wrap: push/drain 3*FIFO_DEPTH+1 distinct words (0x00000001, 0x00000002, ...)
//     -> the received byte stream matches the pushed order exactly.

Source files
------------

// File: rtl/port_out_uart_tx_pkg.sv
// Shared types and constants for the PortOut UART transmitter.
package port_out_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned WORD_W               = 32;
  localparam int unsigned UART_BYTES_PER_WORD  = 4;
  localparam int unsigned UART_BITS_PER_BYTE   = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;
  localparam int unsigned BYTE_IDX_W           = $clog2(UART_BYTES_PER_WORD);
  localparam int unsigned BIT_IDX_W            = $clog2(UART_BITS_PER_BYTE);
  localparam int unsigned BIT_POS_W            = BYTE_IDX_W + BIT_IDX_W;

  // Position of a serial bit inside the word: byte n occupies bits [8n+7:8n].
  function automatic logic [BIT_POS_W-1:0] tx_bit_pos(input logic [BYTE_IDX_W-1:0] byte_idx,
                                                      input logic [BIT_IDX_W-1:0]  bit_idx);
    return {byte_idx, bit_idx};
  endfunction

endpackage

// File: rtl/port_out_uart_tx_sync_fifo.sv
// Small synchronous FIFO with registered pointers, level and full/empty flags.
// The head entry is presented combinationally on dout.
module port_out_uart_tx_sync_fifo
  import port_out_uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LW-1:0]    w_level_nxt;

  assign w_push_ok = push && !r_full;
  assign w_pop_ok  = pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign level = r_level;

endmodule

// File: rtl/port_out_uart_tx.sv
// Processor PortOut sink: buffers written words and sends each as four 8N1 UART
// bytes, least significant byte first. Pushes into a full FIFO are dropped and flagged.
module port_out_uart_tx
  import port_out_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [WORD_W-1:0]           wr_data,
  input  logic                        clear_ovf,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned LW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(UART_BITS_PER_BYTE - 1);
  localparam logic [BYTE_IDX_W-1:0] BYTE_LAST = BYTE_IDX_W'(UART_BYTES_PER_WORD - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [BAUD_W-1:0]     r_baud;
  logic [BAUD_W-1:0]     w_baud_nxt;
  logic [BIT_IDX_W-1:0]  r_bit_idx;
  logic [BIT_IDX_W-1:0]  w_bit_idx_nxt;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [BYTE_IDX_W-1:0] w_byte_idx_nxt;
  logic [WORD_W-1:0]     r_shift;
  logic [WORD_W-1:0]     w_shift_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  r_ovf;
  logic                  w_baud_done;
  logic                  w_pop;
  logic [WORD_W-1:0]     w_fifo_dout;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [LW-1:0]         w_fifo_level;

  port_out_uart_tx_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (w_fifo_level)
  );

  // Sticky overflow; a dropped push wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (wr_en && w_fifo_full) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_baud_done = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_fifo_empty) w_state_nxt = ST_START;
      ST_START: if (w_baud_done) w_state_nxt = ST_DATA;
      ST_DATA:  if (w_baud_done && (r_bit_idx == BIT_LAST)) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_baud_done) w_state_nxt = (r_byte_idx == BYTE_LAST) ? ST_IDLE : ST_START;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter/shift-register updates and the next serial line level.
  always_comb begin
    w_pop          = 1'b0;
    w_baud_nxt     = w_baud_done ? '0 : r_baud + BAUD_W'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_shift_nxt    = r_shift;
    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_nxt    = w_fifo_dout;
          w_byte_idx_nxt = '0;
        end
      end
      ST_START: if (w_baud_done) w_bit_idx_nxt = '0;
      ST_DATA:  if (w_baud_done && (r_bit_idx != BIT_LAST)) w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
      ST_STOP:  if (w_baud_done && (r_byte_idx != BYTE_LAST)) w_byte_idx_nxt = r_byte_idx + BYTE_IDX_W'(1);
      default:  w_baud_nxt = '0;
    endcase
    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[tx_bit_pos(w_byte_idx_nxt, w_bit_idx_nxt)];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign overflow   = r_ovf;
  assign fifo_full  = w_fifo_full;
  assign fifo_empty = w_fifo_empty;
  assign level      = w_fifo_level;

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Bench for port_out_uart_tx: a scoreboard of expected UART bytes checked against
// a serial-line decoder, plus directed checks of flags, latency and timing.
module tb_port_out_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        clear_ovf;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic [2:0]  level;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          mon_en = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  port_out_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clear_ovf  (clear_ovf),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // One clock of stimulus, applied at the falling edge.
  task automatic drive(input bit we, input logic [31:0] d, input bit clr, input bit acc);
    @(negedge clk);
    wr_en     = we;
    wr_data   = d;
    clear_ovf = clr;
    if (we && acc) push_exp(d);
  endtask

  task automatic wait_drain(input int max_cyc, output int t_done);
    bit done;
    done   = 1'b0;
    t_done = -1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && fifo_empty) begin
        done   = 1'b1;
        t_done = cyc;
      end
    end
    check_eq("drain_done", 32'(done), 32'd1);
  endtask

  // Serial decoder: samples each bit mid-period and pops the scoreboard per byte.
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        check_eq("rx_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check_eq("rx_stop_bit", 32'(tx), 32'd1);
        check_eq("rx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          t_end;
    bit          found;
    logic [31:0] w3 [5];
    w3 = '{32'h01234567, 32'h89ABCDEF, 32'h5A5AA5A5, 32'hFF00FF00, 32'h13579BDF};

    // Reset held three cycles
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_empty", 32'(fifo_empty), 32'd1);
    check_eq("rst_full", 32'(fifo_full), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Reset in the middle of a data bit
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check_eq("mid_tx_low", 32'(tx), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd1);
    check_eq("mid_level", 32'(level), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_tx", 32'(tx), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_tx", 32'(tx), 32'd1);
    mon_en = 1'b1;

    // Single word: latency, byte order and frame length
    start_q.delete();
    drive(1'b1, 32'h4F4B0A41, 1'b0, 1'b1);
    c0 = cyc;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("s2_empty_after_push", 32'(fifo_empty), 32'd0);
    check_eq("s2_level_after_push", 32'(level), 32'd1);
    check_eq("s2_busy_before_pop", 32'(busy), 32'd0);
    check_eq("s2_tx_before_pop", 32'(tx), 32'd1);
    @(negedge clk);
    check_eq("s2_busy_after_pop", 32'(busy), 32'd1);
    check_eq("s2_tx_after_pop", 32'(tx), 32'd0);
    check_eq("s2_level_after_pop", 32'(level), 32'd0);
    wait_drain(400, t_end);
    check_eq("s2_start_count", 32'(start_q.size()), 32'd4);
    if (start_q.size() != 0) begin
      check_eq("s2_first_fall", 32'(start_q[0]), 32'(c0 + 2));
      check_eq("s2_frame_len", 32'(t_end - start_q[0]), 32'd160);
    end

    // Back-to-back words, then overflow handling while the FIFO is full
    start_q.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, w3[i], 1'b0, 1'b1);
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check_eq("s3_level_peak", 32'(level), 32'd4);
    check_eq("s3_full", 32'(fifo_full), 32'd1);
    check_eq("s3_no_ovf", 32'(overflow), 32'd0);
    drive(1'b1, 32'h11111111, 1'b1, 1'b0);
    check_eq("s4_ovf_set", 32'(overflow), 32'd1);
    check_eq("s4_level_kept", 32'(level), 32'd4);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("s4_set_beats_clear", 32'(overflow), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("s4_ovf_cleared", 32'(overflow), 32'd0);
    check_eq("s4_level_still_full", 32'(level), 32'd4);
    wait_drain(2000, t_end);
    check_eq("s3_start_count", 32'(start_q.size()), 32'd20);
    if (start_q.size() >= 20) begin
      check_eq("s3_byte_gap", 32'(start_q[1] - start_q[0]), 32'd40);
      for (int w = 1; w < 5; w++)
        check_eq("s3_word_gap", 32'(start_q[4*w] - start_q[4*w-4]), 32'd161);
    end

    // Push coinciding with the pop edge after the FSM returns to idle
    drive(1'b1, 32'hA1A2A3A4, 1'b0, 1'b1);
    drive(1'b1, 32'hB1B2B3B4, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("s5_level_one", 32'(level), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check_eq("s5_idle_seen", 32'(found), 32'd1);
    check_eq("s5_level_pre", 32'(level), 32'd1);
    wr_en   = 1'b1;
    wr_data = 32'hC1C2C3C4;
    push_exp(32'hC1C2C3C4);
    @(negedge clk);
    wr_en = 1'b0;
    check_eq("s5_level_same", 32'(level), 32'd1);
    check_eq("s5_busy", 32'(busy), 32'd1);
    wait_drain(800, t_end);

    // Pointer wrap over 3*DEPTH+1 distinct words
    for (int b = 0; b < 3; b++) begin
      for (int i = 1; i <= 5; i++) begin
        if (b * 5 + i <= 3 * DEPTH + 1) drive(1'b1, 32'(b * 5 + i), 1'b0, 1'b1);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      wait_drain(2000, t_end);
    end
    check_eq("end_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("end_level", 32'(level), 32'd0);
    check_eq("end_ovf", 32'(overflow), 32'd0);
    check_eq("end_tx_idle", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
